decode_in_queue: RTL
====================

// Module: decode_in_queue
// PURPOSE
//  Parametrised instruction staging queue between fetch and decode of the LC3 pipeline.
//  - Captures {dout, npc_in, psr} on each enable_decode beat into a DEPTH-entry circular FIFO.
//  - Presents the oldest entry to decode over a valid/ready handshake.
//  - Back-pressures fetch with in_stall.
//  - Supports a single-cycle flush for taken branches and traps.
// PARAMETERS
//  INSTR_W  16  instruction word width (dout, out_instr)
//  ADDR_W   16  next-PC width (npc_in, out_npc)
//  PSR_W     3  PSR/NZP width (psr, out_psr)
//  DEPTH     4  entry count; power of two, >= 2
//  CNT_W    $clog2(DEPTH+1)  occupancy width (localparam)
// PORTS
//  clock          in   1        sole clock, rising edge
//  reset          in   1        asynchronous, active-high; clears all state
//  enable_decode  in   1        push request; fields below are valid this cycle
//  dout           in   INSTR_W  fetched instruction word
//  npc_in         in   ADDR_W   PC+1 of the instruction
//  psr            in   PSR_W    PSR snapshot
//  flush          in   1        discard all entries (branch/trap redirect)
//  in_stall       out  1        queue full; fetch must hold its outputs
//  out_valid      out  1        head entry available
//  out_ready      in   1        decode accepts head this cycle
//  out_instr      out  INSTR_W  head instruction
//  out_npc        out  ADDR_W   head next-PC
//  out_psr        out  PSR_W    head PSR
//  count          out  CNT_W    current occupancy, 0..DEPTH
//  drop           out  1        1-cycle pulse: push lost to overflow
// BEHAVIOUR
//  Reset: wr_ptr=rd_ptr=count=0; storage cleared to 0; out_valid=0; out_instr/npc/psr=0;
//   in_stall=0; drop=0. Asserting reset mid-transfer discards all entries immediately.
//  pop  = out_valid & out_ready.
//  push = enable_decode & (count<DEPTH | pop); a pop makes room for a same-cycle push.
//  Edge update:
//   - push writes mem[wr_ptr] and increments wr_ptr.
//   - pop increments rd_ptr.
//   - Pointers wrap modulo DEPTH.
//   - count += push - pop; a simultaneous push and pop leaves count unchanged.
//  out_valid = (count!=0); out_* = mem[rd_ptr], combinational from registers.
//  Latency: an entry pushed at edge N is visible at out_* after edge N (1 cycle).
//  Output stability: while out_valid=1 & out_ready=0, out_* hold their values.
//  in_stall = (count==DEPTH); combinational from count; no dependence on out_ready.
//  drop: registered pulse, set for one cycle when enable_decode & full & !pop & !flush.
//   On drop, contents are unchanged.
//  Flush: at the edge where flush=1, pointers and count go to 0.
//   - flush overrides push and pop in the same cycle: the push is lost and drop is not raised.
//   - out_valid=0 on the next cycle.
//  Empty + out_ready: no pop; pointers unchanged.
//  Full + push + pop: the entry is accepted and count stays at DEPTH.
// CONFIGURATION
//  DECODE_IN_Q_BYPASS_EN defined:
//   - When count==0, enable_decode=1 and out_ready=1, the input is forwarded combinationally to out_*.
//   - out_valid=1 that cycle; the entry is consumed and is not written; count stays 0.
//   - If out_ready=0, the normal 1-cycle path applies.
//   - flush=1 blocks the bypass.
//  Undefined: no bypass; minimum latency is 1 cycle; out_* depend only on registers.
// TESTING
//  1 Reset mid-stream: load 3 entries, assert reset -> count=0, out_valid=0, out_instr=0 while reset is high.
//  2 Fill DEPTH=4 with instr 0x1001..0x1004, npc 0x3001..0x3004, out_ready=0
//    -> in_stall=1 and count=4 after the 4th edge.
//    Then a 5th push of 0x1005 -> drop pulses once; head is still 0x1001.
//  3 Full queue, push 0x2000 with out_ready=1 -> 0x1001 popped, count stays 4,
//    and 0x2000 emerges after 0x1004 (pointer wrap).
//  4 Load 2 entries, flush=1 together with enable_decode (0xBEEF) -> next cycle count=0, out_valid=0, drop=0.
//    The next push then appears at out_* one cycle later.
//  5 Back-to-back stream of 16 pushes with out_ready held at 1 -> count stays <=1, no drop,
//    and out_instr sequence equals the input order.
//  6 With DECODE_IN_Q_BYPASS_EN, empty queue, push 0x5020 with out_ready=1
//    -> out_instr=0x5020 and out_valid=1 in the same cycle; count stays 0.

Source files
------------

// File: rtl/decode_in_queue.sv
// ----------------------------------------------------------------------------
// decode_in_queue
//
// Instruction staging queue between fetch and decode of the LC3 pipeline.
// Every enable_decode beat captures {dout, npc_in, psr} into a DEPTH-entry
// circular FIFO. The oldest entry is presented to decode over a valid/ready
// handshake. in_stall back-pressures fetch when the queue is full. flush
// discards all entries in a single cycle on branch or trap redirects.
//
// Parameters
//   INSTR_W  instruction width            (dout, out_instr)
//   ADDR_W   next-PC width                (npc_in, out_npc)
//   PSR_W    PSR/NZP width                (psr, out_psr)
//   DEPTH    entry count, power of two, >= 2
//
// Ports
//   clock          in   sole clock, rising edge
//   reset          in   asynchronous active-high reset, clears all state
//   enable_decode  in   push request; dout/npc_in/psr are valid this cycle
//   dout           in   fetched instruction word
//   npc_in         in   PC+1 of the instruction
//   psr            in   PSR snapshot
//   flush          in   discard all entries (overrides push and pop)
//   in_stall       out  queue full; fetch must hold its outputs
//   out_valid      out  head entry available
//   out_ready      in   decode accepts the head this cycle
//   out_instr      out  head instruction
//   out_npc        out  head next-PC
//   out_psr        out  head PSR
//   count          out  current occupancy, 0..DEPTH
//   drop           out  one-cycle pulse: a push was lost to overflow
//
// Configuration macro
//   DECODE_IN_Q_BYPASS_EN  when defined, an empty queue forwards the input
//                          combinationally to out_* if decode is ready, and
//                          no entry is written. When undefined, the minimum
//                          latency is one cycle and out_* depend only on
//                          registers.
// ----------------------------------------------------------------------------
module decode_in_queue #(
   parameter int INSTR_W = 16,
   parameter int ADDR_W  = 16,
   parameter int PSR_W   = 3,
   parameter int DEPTH   = 4,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable_decode,
   input  logic [INSTR_W-1:0] dout,
   input  logic [ADDR_W-1:0]  npc_in,
   input  logic [PSR_W-1:0]   psr,
   input  logic               flush,
   output logic               in_stall,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_npc,
   output logic [PSR_W-1:0]   out_psr,
   output logic [CNT_W-1:0]   count,
   output logic               drop
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  npc;
      logic [PSR_W-1:0]   psr;
   } entry_t;

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               full;
   logic               not_empty;
   logic               bypass;
   logic               pop;
   logic               push;
   entry_t             in_entry;
   entry_t             head;

   assign in_entry  = '{instr: dout, npc: npc_in, psr: psr};
   assign head      = mem[rd_ptr];
   assign full      = (count == CNT_W'(DEPTH));
   assign not_empty = (count != '0);

`ifdef DECODE_IN_Q_BYPASS_EN
   // Empty queue with a ready consumer: the beat goes straight through and
   // is never stored. A flush in the same cycle kills the forwarded beat.
   assign bypass = ~not_empty & enable_decode & out_ready & ~flush;
`else
   assign bypass = 1'b0;
`endif

   // Only a stored entry can be popped; a bypassed beat never touches state.
   assign pop  = not_empty & out_ready;
   // A pop frees the slot, so a full queue still accepts a same-cycle push.
   assign push = enable_decode & (~full | pop) & ~bypass;

   assign in_stall  = full;
   assign out_valid = not_empty | bypass;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      out_instr = head.instr;
      out_npc   = head.npc;
      out_psr   = head.psr;
      if (bypass) begin
         out_instr = in_entry.instr;
         out_npc   = in_entry.npc;
         out_psr   = in_entry.psr;
      end
   end

   // NOTE: storage is reset along with the pointers because out_* are read
   // straight from mem and must be zero after reset; sequential state is
   // updated only with non-blocking assignments so all registers sample the
   // same pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         drop   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         // Overflow: the push is refused, contents untouched. A flush
         // supersedes the lost push, so no drop is reported then.
         drop <= enable_decode & full & ~pop & ~flush;

         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) begin
               mem[wr_ptr] <= in_entry;
               wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
               count <= count + CNT_W'(1);
            end else if (pop && !push) begin
               count <= count - CNT_W'(1);
            end
         end
      end
   end

endmodule
